mac_match_engine: RTL and testbench

//  Multi-entry successor of the single-MAC stream comparator. Scans a byte stream for any of NUM_MACS
//  48-bit flagged MACs at any byte alignment. Passes the data through a fixed-latency delay line. The

---
 rtl/eth_sniffer_pkg.sv | 15 +
 rtl/mac_window_search.sv | 40 ++++
 rtl/mac_match_engine.sv | 188 ++++++++++++++++++
 tb/tb_mac_match_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sniffer_pkg.sv
// Shared types and helpers for the Ethernet sniffer datapath blocks.
package eth_sniffer_pkg;

    localparam int unsigned MAC_W = 48;

    typedef logic [MAC_W-1:0] mac_t;

    typedef enum logic [1:0] {SEARCH, ARMED, MATCHED} mme_state_t;

    // Words of look-ahead needed so a MAC starting at any byte of the oldest word fits.
    function automatic int unsigned win_words(input int unsigned bytes);
        return (2 * bytes + 4) / bytes;
    endfunction

endpackage

// File: rtl/mac_window_search.sv
// Combinational search of one MAC entry against every byte alignment of the oldest window word.
// Reports a hit and the lowest matching byte offset.
module mac_window_search
    import eth_sniffer_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned WIN        = win_words(DATA_BYTES),
    localparam int unsigned SPAN      = 8 * (DATA_BYTES - 1) + MAC_W,
    localparam int unsigned OFF_W     = $clog2(DATA_BYTES)
) (
    input  logic [SPAN-1:0]  window,
    input  logic [WIN-1:0]   win_vld,
    input  mac_t             mac,
    input  logic             enable,
    output logic             hit,
    output logic [OFF_W-1:0] offset
);

    logic ok;

    // Scan high to low so the lowest matching offset is the one left standing.
    always_comb begin
        hit    = 1'b0;
        offset = '0;
        ok     = 1'b0;
        for (int b = int'(DATA_BYTES) - 1; b >= 0; b--) begin
            ok = (window[8*b +: MAC_W] == mac) && enable;
            for (int w = 0; w < int'(WIN); w++) begin
                if (w <= (b + 5) / int'(DATA_BYTES) && !win_vld[w]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                hit    = 1'b1;
                offset = OFF_W'(b);
            end
        end
    end

endmodule

// File: rtl/mac_match_engine.sv
// Fixed-latency pass-through that flags the word in which any enabled MAC entry starts.
// Optional hit counter output enabled by defining MAC_HIT_COUNT_EN.
module mac_match_engine
    import eth_sniffer_pkg::*;
#(
    parameter int unsigned NUM_MACS   = 4,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned DELAY      = 4,
    localparam int unsigned DW        = 8 * DATA_BYTES,
    localparam int unsigned IDX_W     = $clog2(NUM_MACS),
    localparam int unsigned OFF_W     = $clog2(DATA_BYTES)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      clear,
    input  logic                      data_valid,
    input  logic [DW-1:0]             data_in,
    input  logic [MAC_W*NUM_MACS-1:0] flagged_mac,
    input  logic [NUM_MACS-1:0]       mac_enable,
    output logic [DW-1:0]             data_out,
    output logic                      data_out_vld,
    output logic                      match,
    output logic [IDX_W-1:0]          match_idx,
    output logic [OFF_W-1:0]          match_offset
`ifdef MAC_HIT_COUNT_EN
    ,
    output logic [15:0]               hit_count
`endif
);

    localparam int unsigned WIN  = win_words(DATA_BYTES);
    localparam int unsigned SPAN = 8 * (DATA_BYTES - 1) + MAC_W;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } tag_t;

    logic [DW-1:0]    word_q [DELAY];
    logic [DELAY-1:0] vld_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned k = 0; k < DELAY; k++) word_q[k] <= '0;
            vld_q <= '0;
        end else if (clear) begin
            for (int unsigned k = 0; k < DELAY; k++) word_q[k] <= '0;
            vld_q <= '0;
        end else begin
            word_q[0] <= data_valid ? data_in : '0;
            for (int unsigned k = 1; k < DELAY; k++) word_q[k] <= word_q[k-1];
            vld_q <= {vld_q[DELAY-2:0], data_valid};
        end
    end

    // Window bit 0 is byte 0 of the oldest word; bytes past the last candidate slice are dropped.
    logic [SPAN-1:0] window;
    logic [WIN-1:0]  win_vld;

    for (genvar w = 0; w < WIN; w++) begin : g_win
        if ((w + 1) * DW <= SPAN) begin : g_full
            assign window[w*DW +: DW] = word_q[WIN-1-w];
        end else begin : g_part
            assign window[SPAN-1:w*DW] = word_q[WIN-1-w][SPAN-1-w*DW:0];
        end
        assign win_vld[w] = vld_q[WIN-1-w];
    end

    logic [NUM_MACS-1:0] ent_hit;
    logic [OFF_W-1:0]    ent_off [NUM_MACS];

    for (genvar i = 0; i < NUM_MACS; i++) begin : g_search
        mac_window_search #(
            .DATA_BYTES (DATA_BYTES),
            .WIN        (WIN)
        ) u_search (
            .window  (window),
            .win_vld (win_vld),
            .mac     (flagged_mac[MAC_W*i +: MAC_W]),
            .enable  (mac_enable[i]),
            .hit     (ent_hit[i]),
            .offset  (ent_off[i])
        );
    end

    tag_t tag_new;

    always_comb begin
        tag_new = '0;
        for (int i = int'(NUM_MACS) - 1; i >= 0; i--) begin
            if (ent_hit[i]) begin
                tag_new.hit = 1'b1;
                tag_new.idx = IDX_W'(i);
                tag_new.off = ent_off[i];
            end
        end
    end

    // Tag that lands on data_out at the coming edge, alongside its word.
    tag_t tag_arrive;

    if (DELAY > WIN + 1) begin : g_tag_pipe
        tag_t tag_q [WIN:DELAY-2];

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                for (int unsigned k = WIN; k <= DELAY - 2; k++) tag_q[k] <= '0;
            end else if (clear) begin
                for (int unsigned k = WIN; k <= DELAY - 2; k++) tag_q[k] <= '0;
            end else begin
                tag_q[WIN] <= tag_new;
                for (int unsigned k = WIN + 1; k <= DELAY - 2; k++) tag_q[k] <= tag_q[k-1];
            end
        end

        assign tag_arrive = tag_q[DELAY-2];
    end else begin : g_no_tag_pipe
        assign tag_arrive = tag_new;
    end

    mme_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [OFF_W-1:0] off_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = SEARCH;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    if (tag_arrive.hit)   state_d = MATCHED;
                    else if (tag_new.hit) state_d = ARMED;
                end
                ARMED:   if (tag_arrive.hit) state_d = MATCHED;
                MATCHED: state_d = MATCHED;
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx_q <= '0;
            off_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
            off_q <= '0;
        end else if (state_q != MATCHED && state_d == MATCHED) begin
            idx_q <= tag_arrive.idx;
            off_q <= tag_arrive.off;
        end
    end

    always_comb begin
        match        = (state_q == MATCHED);
        match_idx    = idx_q;
        match_offset = off_q;
        data_out     = word_q[DELAY-1];
        data_out_vld = vld_q[DELAY-1];
    end

`ifdef MAC_HIT_COUNT_EN
    logic [15:0] hit_count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hit_count_q <= '0;
        end else if (clear) begin
            hit_count_q <= '0;
        end else if (tag_new.hit && hit_count_q != 16'hFFFF) begin
            hit_count_q <= hit_count_q + 16'd1;
        end
    end

    assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_mac_match_engine.sv
// Directed bench for mac_match_engine (NUM_MACS=4, DATA_BYTES=4, DELAY=4).
// Build with MAC_HIT_COUNT_EN defined to also exercise the hit counter.
module tb_mac_match_engine;

    localparam int unsigned NUM_MACS   = 4;
    localparam int unsigned DATA_BYTES = 4;
    localparam int unsigned DELAY      = 4;
    localparam logic [47:0] MAC        = 48'hA1B2C3D4E5F6;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         clear;
    logic         data_valid;
    logic [31:0]  data_in;
    logic [191:0] flagged_mac;
    logic [3:0]   mac_enable;
    logic [31:0]  data_out;
    logic         data_out_vld;
    logic         match;
    logic [1:0]   match_idx;
    logic [1:0]   match_offset;
`ifdef MAC_HIT_COUNT_EN
    logic [15:0]  hit_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_match_engine #(
        .NUM_MACS   (NUM_MACS),
        .DATA_BYTES (DATA_BYTES),
        .DELAY      (DELAY)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .flagged_mac  (flagged_mac),
        .mac_enable   (mac_enable),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .match        (match),
        .match_idx    (match_idx),
        .match_offset (match_offset)
`ifdef MAC_HIT_COUNT_EN
        ,
        .hit_count    (hit_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic v, input logic [31:0] w);
        data_valid = v;
        data_in    = w;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data_in    = '0;
    endtask

    task automatic do_clear();
        clear      = 1'b1;
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Three words then a zero word: afterwards data_out holds w0.
    task automatic run_hit(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        push(1'b1, w0);
        push(1'b1, w1);
        push(1'b1, w2);
        push(1'b1, 32'h0);
    endtask

    logic [31:0] off_w0 [3];
    logic [31:0] off_w1 [3];
    logic [31:0] off_w2 [3];
    logic [1:0]  off_exp [3];

    initial begin
        off_w0 = '{32'hF6000000, 32'hD4E5F600, 32'hC3D4E5F6};
        off_w1 = '{32'hB2C3D4E5, 32'h00A1B2C3, 32'h0000A1B2};
        off_w2 = '{32'h000000A1, 32'h00000000, 32'h00000000};
        off_exp = '{2'd3, 2'd1, 2'd0};

        n_rst       = 1'b0;
        clear       = 1'b0;
        data_valid  = 1'b0;
        data_in     = '0;
        flagged_mac = '0;
        flagged_mac[96 +: 48] = MAC;
        mac_enable  = 4'b0100;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_match", match, 0);
        check_eq("rst_vld", data_out_vld, 0);
        check_eq("rst_data", data_out, 0);
        n_rst = 1'b1;
        push(1'b0, 32'h0);

        // Asynchronous reset mid-stream after a match has been raised
        run_hit(32'hE5F60000, 32'hA1B2C3D4, 32'h0);
        check_eq("pre_rst_match", match, 1);
        #2 n_rst = 1'b0;
        #1;
        check_eq("async_rst_match", match, 0);
        check_eq("async_rst_data", data_out, 0);
        check_eq("async_rst_vld", data_out_vld, 0);
        check_eq("async_rst_idx", match_idx, 0);
        check_eq("async_rst_off", match_offset, 0);
        #1 n_rst = 1'b1;
        repeat (5) push(1'b1, 32'h0);
        check_eq("post_rst_match", match, 0);

        // MAC split across two words, starting at byte 2 of the first
        run_hit(32'hE5F60000, 32'hA1B2C3D4, 32'h0);
        check_eq("b2_data", data_out, 32'hE5F60000);
        check_eq("b2_match", match, 1);
        check_eq("b2_idx", match_idx, 2);
        check_eq("b2_off", match_offset, 2);
        push(1'b1, 32'h0);
        check_eq("b2_next_data", data_out, 32'hA1B2C3D4);
        check_eq("b2_hold", match, 1);

        // A later hit on another entry must not disturb the held result
        flagged_mac[0 +: 48] = MAC;
        mac_enable = 4'b0101;
        run_hit(32'hC3D4E5F6, 32'h0000A1B2, 32'h0);
        check_eq("held_idx", match_idx, 2);
        check_eq("held_off", match_offset, 2);
        flagged_mac[0 +: 48] = '0;
        mac_enable = 4'b0100;
        do_clear();
        check_eq("clr_match", match, 0);
        check_eq("clr_idx", match_idx, 0);

        for (int t = 0; t < 3; t++) begin
            run_hit(off_w0[t], off_w1[t], off_w2[t]);
            check_eq("off_data", data_out, off_w0[t]);
            check_eq("off_match", match, 1);
            check_eq("off_val", match_offset, off_exp[t]);
            do_clear();
        end

        // Priority across entries
        flagged_mac[48 +: 48]  = MAC;
        flagged_mac[144 +: 48] = MAC;
        mac_enable = 4'b1010;
        run_hit(32'hC3D4E5F6, 32'h0000A1B2, 32'h0);
        check_eq("prio_1010", match_idx, 1);
        do_clear();
        mac_enable = 4'b1000;
        run_hit(32'hC3D4E5F6, 32'h0000A1B2, 32'h0);
        check_eq("prio_1000", match_idx, 3);
        do_clear();
        flagged_mac = '0;
        flagged_mac[96 +: 48] = MAC;
        mac_enable = 4'b0100;

        // Bubble between the two halves of the MAC
        push(1'b1, 32'hE5F60000);
        push(1'b0, 32'h0);
        push(1'b1, 32'hA1B2C3D4);
        push(1'b1, 32'h0);
        check_eq("bub_data", data_out, 32'hE5F60000);
        check_eq("bub_match", match, 0);
        push(1'b1, 32'h0);
        check_eq("bub_gap_vld", data_out_vld, 0);
        push(1'b1, 32'h0);
        check_eq("bub_after_data", data_out, 32'hA1B2C3D4);
        repeat (2) push(1'b1, 32'h0);
        check_eq("bub_no_match", match, 0);

        // clear presented together with the second word drops it
        push(1'b1, 32'hE5F60000);
        clear = 1'b1;
        data_valid = 1'b1;
        data_in = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        clear = 1'b0;
        data_valid = 1'b0;
        data_in = '0;
        repeat (4) push(1'b1, 32'h0);
        check_eq("clr2_data", data_out, 0);
        check_eq("clr2_match", match, 0);

        // clear in the cycle the compare hits
        push(1'b1, 32'hE5F60000);
        push(1'b1, 32'hA1B2C3D4);
        push(1'b1, 32'h0);
        do_clear();
        repeat (4) push(1'b1, 32'h0);
        check_eq("clr_hit_match", match, 0);

`ifdef MAC_HIT_COUNT_EN
        check_eq("cnt_start", hit_count, 0);
        for (int r = 0; r < 3; r++) run_hit(32'hE5F60000, 32'hA1B2C3D4, 32'h0);
        check_eq("cnt_three", hit_count, 3);
        check_eq("cnt_idx", match_idx, 2);
        do_clear();
        check_eq("cnt_clr", hit_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
